// File: rtl/csr_hpm_pkg.sv
// csr_defines: CSR address map, ID constants and event-selector type
// shared by csr_hpm and its counters.
package csr_defines;

    // Exact-match addresses
    localparam logic [11:0] ADDR_MISA          = 12'h301;
    localparam logic [11:0] ADDR_MVENDORID     = 12'hF11;
    localparam logic [11:0] ADDR_MARCHID       = 12'hF12;
    localparam logic [11:0] ADDR_MCOUNTINHIBIT = 12'h320;

    // 32-entry blocks, matched on addr[11:5]; addr[4:0] is the counter number
    localparam logic [6:0] BLK_MHPMEVENT = 7'h19;  // 0x320..0x33F
    localparam logic [6:0] BLK_MCNT_LO   = 7'h58;  // 0xB00..0xB1F
    localparam logic [6:0] BLK_MCNT_HI   = 7'h5C;  // 0xB80..0xB9F
    localparam logic [6:0] BLK_UCNT_LO   = 7'h60;  // 0xC00..0xC1F
    localparam logic [6:0] BLK_UCNT_HI   = 7'h64;  // 0xC80..0xC9F

    // RV32IM, machine mode only
    localparam logic [31:0] MISA_VAL      = 32'h4000_1100;
    localparam logic [31:0] MVENDORID_VAL = 32'h0000_0000;
    localparam logic [31:0] MARCHID_VAL   = 32'h0000_002A;

    localparam int SEL_W = 5;
    typedef logic [SEL_W-1:0] evt_sel_t;

    // Counter slot j -> CSR counter number: slot 0 mcycle(0), slot 1
    // minstret(2), slot 2+i hpm(3+i).
    function automatic logic [4:0] cnt_num(input int j);
        return (j == 0) ? 5'd0 : 5'(j + 1);
    endfunction

endpackage

// File: rtl/hpm_counter.sv
// hpm_counter: one CNT_W-bit counter with independent 32-bit low/high
// half writes (write beats increment) and a wrap pulse for overflow.
module hpm_counter #(
    parameter int CNT_W = 64
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             wr_lo,
    input  logic             wr_hi,
    input  logic [31:0]      wdata,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap
);

    // only an increment-driven all-ones -> 0 transition counts as a wrap
    assign wrap = inc & ~wr_lo & ~wr_hi & (&cnt);

    // half write has priority over increment
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (wr_lo)
            cnt[31:0] <= wdata;
        else if (wr_hi)
            cnt[CNT_W-1:32] <= wdata[CNT_W-33:0];
        else if (inc)
            cnt <= cnt + CNT_W'(1);
    end

endmodule

// File: rtl/csr_hpm.sv
// csr_hpm: machine counter/ID CSR file -- mcycle, minstret, NUM_HPM
// programmable hpmcounters with event selectors, mcountinhibit and user
// read-only shadows. Optional macro HPM_OVF_IRQ_EN adds the sticky OF bit
// in mhpmevent[31] and a registered overflow interrupt.
module csr_hpm
    import csr_defines::*;
#(
    parameter int NUM_HPM = 4,
    parameter int CNT_W   = 64,
    parameter int EVT_W   = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             wen,
    input  logic [11:0]      addr,
    input  logic [31:0]      wdata,
    input  logic             is_inst_ret,
    input  logic [EVT_W-1:0] events,
    output logic [31:0]      rdata,
    output logic             illegal,
    output logic             ovf_irq
);

    localparam int NCNT = NUM_HPM + 2;
    localparam logic [31:0] INH_MASK = (((32'd1 << NUM_HPM) - 32'd1) << 3) | 32'h5;

    logic [NCNT-1:0][CNT_W-1:0] cnt;
    logic [NCNT-1:0]            inc, wr_lo, wr_hi, wrap;
    logic [31:0]                inh_q;
    evt_sel_t [NUM_HPM-1:0]     sel_q;
    logic [NUM_HPM-1:0]         evt_we;
    logic                       inh_we;
    logic [63:0]                cval;
    logic [4:0]                 n;
    logic [6:0]                 blk;
    logic                       hi, ro;
`ifdef HPM_OVF_IRQ_EN
    logic [NUM_HPM-1:0]         of_q;
    logic                       ovf_q;
`endif

    assign n   = addr[4:0];
    assign blk = addr[11:5];
    assign hi  = addr[7];
    assign ro  = (addr[11:8] == 4'hC);

    // address decode: read mux, illegal flag and per-register write strobes
    always_comb begin
        rdata   = '0;
        illegal = 1'b1;
        wr_lo   = '0;
        wr_hi   = '0;
        evt_we  = '0;
        inh_we  = 1'b0;
        cval    = '0;
        if (addr == ADDR_MISA) begin
            rdata   = MISA_VAL;
            illegal = wen;
        end else if (addr == ADDR_MVENDORID) begin
            rdata   = MVENDORID_VAL;
            illegal = wen;
        end else if (addr == ADDR_MARCHID) begin
            rdata   = MARCHID_VAL;
            illegal = wen;
        end else if (addr == ADDR_MCOUNTINHIBIT) begin
            rdata   = inh_q;
            illegal = 1'b0;
            inh_we  = wen;
        end else if (blk == BLK_MHPMEVENT) begin
            for (int i = 0; i < NUM_HPM; i++) begin
                if (n == 5'(3 + i)) begin
                    rdata = {27'd0, sel_q[i]};
`ifdef HPM_OVF_IRQ_EN
                    rdata[31] = of_q[i];
`endif
                    illegal   = 1'b0;
                    evt_we[i] = wen;
                end
            end
        end else if (blk == BLK_MCNT_LO || blk == BLK_MCNT_HI ||
                     blk == BLK_UCNT_LO || blk == BLK_UCNT_HI) begin
            for (int j = 0; j < NCNT; j++) begin
                if (n == cnt_num(j)) begin
                    cval     = 64'(cnt[j]);
                    rdata    = hi ? cval[63:32] : cval[31:0];
                    illegal  = ro & wen;
                    wr_lo[j] = wen & ~ro & ~hi;
                    wr_hi[j] = wen & ~ro & hi;
                end
            end
        end
    end

    assign inc[0] = ~inh_q[0];
    assign inc[1] = is_inst_ret & ~inh_q[2];

    for (genvar i = 0; i < NUM_HPM; i++) begin : g_evt
        logic ev_hit;
        // selected event for this counter; selector 0 or >EVT_W never matches
        always_comb begin
            ev_hit = 1'b0;
            for (int k = 0; k < EVT_W; k++)
                if (sel_q[i] == evt_sel_t'(k + 1)) ev_hit = events[k];
        end
        assign inc[2+i] = ev_hit & ~inh_q[3+i];
    end

    for (genvar j = 0; j < NCNT; j++) begin : g_cnt
        hpm_counter #(.CNT_W(CNT_W)) u_cnt (
            .clock   (clock),
            .reset_n (reset_n),
            .wr_lo   (wr_lo[j]),
            .wr_hi   (wr_hi[j]),
            .wdata   (wdata),
            .inc     (inc[j]),
            .cnt     (cnt[j]),
            .wrap    (wrap[j])
        );
    end

    // mcountinhibit and event selectors; unimplemented inhibit bits stay 0
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            inh_q <= '0;
            sel_q <= '0;
        end else begin
            if (inh_we) inh_q <= wdata & INH_MASK;
            for (int i = 0; i < NUM_HPM; i++)
                if (evt_we[i]) sel_q[i] <= wdata[SEL_W-1:0];
        end
    end

`ifdef HPM_OVF_IRQ_EN
    // sticky OF: a wrap in the same cycle as a clearing write still sets it;
    // irq follows the OR of OF bits one cycle later
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            of_q  <= '0;
            ovf_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_HPM; i++)
                of_q[i] <= (evt_we[i] ? wdata[31] : of_q[i]) | wrap[2+i];
            ovf_q <= |of_q;
        end
    end
    assign ovf_irq = ovf_q;
`else
    assign ovf_irq = 1'b0;
`endif

    // mcycle/minstret wraps (and all wraps without the irq) have no consumer
    logic unused_wrap;
    assign unused_wrap = ^wrap;

endmodule

// File: tb/tb_csr_hpm.sv
// tb_csr_hpm: table-driven vectors, directed corner sequences and random
// traffic checked against a behavioural model of the CSR file.
// Build with HPM_OVF_IRQ_EN defined to exercise the overflow flag/irq.
module tb_csr_hpm;
    import csr_defines::*;

    localparam int NH = 4;
    localparam int CW = 40;
    localparam int EW = 8;
`ifdef HPM_OVF_IRQ_EN
    localparam bit OF_EN = 1'b1;
`else
    localparam bit OF_EN = 1'b0;
`endif
    localparam longint unsigned MASK = (CW == 64) ? 64'hFFFF_FFFF_FFFF_FFFF
                                                  : ((64'd1 << CW) - 64'd1);

    logic          clock = 1'b0;
    logic          reset_n;
    logic          wen;
    logic [11:0]   addr;
    logic [31:0]   wdata;
    logic          is_inst_ret;
    logic [EW-1:0] events;
    logic [31:0]   rdata;
    logic          illegal;
    logic          ovf_irq;

    always #5 clock = ~clock;

    csr_hpm #(.NUM_HPM(NH), .CNT_W(CW), .EVT_W(EW)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .wen         (wen),
        .addr        (addr),
        .wdata       (wdata),
        .is_inst_ret (is_inst_ret),
        .events      (events),
        .rdata       (rdata),
        .illegal     (illegal),
        .ovf_irq     (ovf_irq)
    );

    int tests = 0;
    int fails = 0;

    // ---------------- behavioural model ----------------
    longint unsigned m_cnt[32];
    logic [4:0]      m_sel[32];
    bit              m_of[32];
    logic [31:0]     m_inh;
    bit              m_irq;

    function automatic bit is_cnt(int k);
        return k == 0 || k == 2 || (k >= 3 && k < 3 + NH);
    endfunction

    function automatic bit is_hpm(int k);
        return k >= 3 && k < 3 + NH;
    endfunction

    function automatic logic [31:0] inh_mask();
        logic [31:0] m = 32'h1 | 32'h4;
        for (int k = 3; k < 3 + NH; k++) m[k] = 1'b1;
        return m;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 32; k++) begin
            m_cnt[k] = 0; m_sel[k] = '0; m_of[k] = 0;
        end
        m_inh = '0;
        m_irq = 0;
    endtask

    task automatic model_read(input logic w, input logic [11:0] a,
                              output logic [31:0] rd, output logic ill);
        int k = int'(a[4:0]);
        logic [11:0] base = a & 12'hFE0;
        longint unsigned v;
        rd = '0; ill = 1'b1;
        if (a == 12'h301)      begin rd = MISA_VAL;      ill = w; end
        else if (a == 12'hF11) begin rd = MVENDORID_VAL; ill = w; end
        else if (a == 12'hF12) begin rd = MARCHID_VAL;   ill = w; end
        else if (a == 12'h320) begin rd = m_inh;         ill = 1'b0; end
        else if (base == 12'h320 && is_hpm(k)) begin
            rd  = {27'd0, m_sel[k]} | (m_of[k] ? 32'h8000_0000 : 32'h0);
            ill = 1'b0;
        end else if ((base == 12'hB00 || base == 12'hB80 ||
                      base == 12'hC00 || base == 12'hC80) && is_cnt(k)) begin
            v   = m_cnt[k];
            rd  = a[7] ? v[63:32] : v[31:0];
            ill = w && (a[11:8] == 4'hC);
        end
    endtask

    task automatic model_step(input logic w, input logic [11:0] a, input logic [31:0] d,
                              input logic r, input logic [EW-1:0] e);
        int k = int'(a[4:0]);
        logic [11:0] base = a & 12'hFE0;
        bit inc[32];
        bit wrp[32];
        bit any_of = 0;
        int s;
        for (int q = 0; q < 32; q++) begin inc[q] = 0; wrp[q] = 0; end
        for (int q = 3; q < 3 + NH; q++) any_of |= m_of[q];
        inc[0] = !m_inh[0];
        inc[2] = r && !m_inh[2];
        for (int q = 3; q < 3 + NH; q++) begin
            s = int'(m_sel[q]);
            inc[q] = (s >= 1 && s <= EW) ? (e[s-1] && !m_inh[q]) : 0;
        end
        for (int q = 0; q < 32; q++) begin
            if (!is_cnt(q)) continue;
            if (w && base == 12'hB00 && k == q)
                m_cnt[q] = (m_cnt[q] & 64'hFFFF_FFFF_0000_0000) | {32'h0, d};
            else if (w && base == 12'hB80 && k == q)
                m_cnt[q] = ((m_cnt[q] & 64'hFFFF_FFFF) | {d, 32'h0}) & MASK;
            else if (inc[q]) begin
                if (m_cnt[q] == MASK) begin m_cnt[q] = 0; wrp[q] = 1; end
                else m_cnt[q] = m_cnt[q] + 1;
            end
        end
        if (w && base == 12'h320 && is_hpm(k)) begin
            m_sel[k] = d[4:0];
            if (OF_EN) m_of[k] = d[31];
        end
        for (int q = 3; q < 3 + NH; q++) if (OF_EN && wrp[q]) m_of[q] = 1;
        if (w && a == 12'h320) m_inh = d & inh_mask();
        m_irq = OF_EN && any_of;
    endtask

    // ---------------- drive / check ----------------
    logic [31:0] act_rd, exp_rd;
    logic        act_ill, exp_ill, act_irq, exp_irq;

    task automatic step(input logic w, input logic [11:0] a, input logic [31:0] d,
                        input logic r, input logic [EW-1:0] e);
        @(negedge clock);
        wen = w; addr = a; wdata = d; is_inst_ret = r; events = e;
        #1;
        act_rd = rdata; act_ill = illegal; act_irq = ovf_irq;
        model_read(w, a, exp_rd, exp_ill);
        exp_irq = m_irq;
        @(posedge clock);
        model_step(w, a, d, r, e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic chk_model(input string nm);
        chk({nm, ".rdata"}, act_rd, exp_rd);
        chk({nm, ".illegal"}, 32'(act_ill), 32'(exp_ill));
        chk({nm, ".ovf_irq"}, 32'(act_irq), 32'(exp_irq));
    endtask

    typedef struct {
        logic        w;
        logic [11:0] a;
        logic [31:0] d;
        logic [31:0] rd;
        logic        ill;
    } vec_t;

    vec_t vt[$];

    logic [11:0] raddr[$] = '{12'h301, 12'hF11, 12'hF12, 12'h320, 12'h321, 12'h323,
                              12'h324, 12'h325, 12'h326, 12'h327, 12'hB00, 12'hB80,
                              12'hB01, 12'hB02, 12'hB82, 12'hB03, 12'hB04, 12'hB05,
                              12'hB06, 12'hB83, 12'hB86, 12'hB07, 12'hC00, 12'hC80,
                              12'hC02, 12'hC82, 12'hC03, 12'hC86, 12'h7FF, 12'hB1F};

    longint unsigned cap_c, cap_i;

    initial begin
        reset_n = 1'b0; wen = 0; addr = 12'hB00; wdata = 0; is_inst_ret = 0; events = '0;
        model_reset();
        #23;
        @(posedge clock); #1 reset_n = 1'b1;

        // reset state, then 10 idle cycles (no pipeline offset: read is combinational)
        step(0, 12'hB00, 0, 0, '0);
        chk("reset_mcycle", act_rd, 32'd0);
        chk("reset_illegal", 32'(act_ill), 32'd0);
        chk("reset_irq", 32'(act_irq), 32'd0);
        for (int i = 0; i < 9; i++) step(0, 12'hB00, 0, 0, '0);
        step(0, 12'hB00, 0, 0, '0);
        chk("idle10_mcycle", act_rd, 32'd10);
        step(0, 12'hB02, 0, 0, '0);
        chk("idle_minstret", act_rd, 32'd0);
        step(0, 12'hC00, 0, 0, '0);
        chk("shadow_cycle", act_rd, 32'd12);
        chk("shadow_illegal", 32'(act_ill), 32'd0);

        // constant-outcome table
        vt.push_back('{0, 12'h301, 32'h0,        MISA_VAL,       0});
        vt.push_back('{1, 12'h301, 32'h1234,     MISA_VAL,       1});
        vt.push_back('{0, 12'hF11, 32'h0,        MVENDORID_VAL,  0});
        vt.push_back('{0, 12'hF12, 32'h0,        MARCHID_VAL,    0});
        vt.push_back('{0, 12'h7FF, 32'h0,        32'h0,          1});
        vt.push_back('{1, 12'h7FF, 32'hFFFF,     32'h0,          1});
        vt.push_back('{0, 12'h321, 32'h0,        32'h0,          1});
        vt.push_back('{1, 12'h323, 32'hFFFFFFFF, 32'h0,          0});
        vt.push_back('{0, 12'h323, 32'h0,        (OF_EN ? 32'h8000001F : 32'h1F), 0});
        vt.push_back('{1, 12'h323, 32'h0,        (OF_EN ? 32'h8000001F : 32'h1F), 0});
        vt.push_back('{1, 12'h320, 32'hFFFFFFFF, 32'h0,          0});
        vt.push_back('{0, 12'h320, 32'h0,        32'h7D,         0});
        vt.push_back('{1, 12'h320, 32'h0,        32'h7D,         0});
        vt.push_back('{0, 12'h327, 32'h0,        32'h0,          1});
        vt.push_back('{0, 12'hB01, 32'h0,        32'h0,          1});
        vt.push_back('{1, 12'hC83, 32'h5,        32'h0,          1});
        vt.push_back('{0, 12'hB07, 32'h0,        32'h0,          1});
        vt.push_back('{0, 12'h324, 32'h0,        32'h0,          0});
        for (int i = 0; i < vt.size(); i++) begin
            step(vt[i].w, vt[i].a, vt[i].d, 0, '0);
            chk($sformatf("tbl%0d.rdata", i), act_rd, vt[i].rd);
            chk($sformatf("tbl%0d.illegal", i), 32'(act_ill), 32'(vt[i].ill));
        end

        // event selection: only events[1] counts into hpm3
        step(1, 12'h323, 32'd2, 0, '0);
        for (int i = 0; i < 5; i++) step(0, 12'hB03, 0, 0, 8'h02);
        for (int i = 0; i < 3; i++) step(0, 12'hB03, 0, 0, 8'h01);
        step(0, 12'hB03, 0, 0, '0);
        chk("hpm3_count", act_rd, 32'd5);

        // mcountinhibit freezes CY and IR, release resumes
        step(1, 12'h320, 32'h5, 1, '0);
        cap_c = m_cnt[0]; cap_i = m_cnt[2];
        for (int i = 0; i < 20; i++) step(0, 12'hB00, 0, 1, '0);
        step(0, 12'hB00, 0, 1, '0);
        chk("inhibit_mcycle", act_rd, cap_c[31:0]);
        step(0, 12'hB02, 0, 1, '0);
        chk("inhibit_minstret", act_rd, cap_i[31:0]);
        step(1, 12'h320, 32'h0, 1, '0);
        step(0, 12'hB02, 0, 1, '0);
        step(0, 12'hB02, 0, 1, '0);
        chk("resume_minstret", act_rd, cap_i[31:0] + 32'd1);
        step(0, 12'hB00, 0, 0, '0);
        chk("resume_mcycle", act_rd, cap_c[31:0] + 32'd2);

        // wrap of hpm3: high half truncated to CNT_W
        step(1, 12'h323, 32'h0, 0, '0);
        step(1, 12'hB83, 32'hFFFFFFFF, 0, '0);
        step(1, 12'hB03, 32'hFFFFFFFE, 0, '0);
        step(1, 12'h323, 32'h1, 0, 8'h01);
        step(0, 12'hB83, 0, 0, 8'h01);
        chk("wrap_hi_pre", act_rd, 32'h000000FF);
        step(0, 12'hB03, 0, 0, 8'h01);
        chk("wrap_lo_ff", act_rd, 32'hFFFFFFFF);
        step(0, 12'hB03, 0, 0, '0);
        chk("wrap_lo_0", act_rd, 32'h0);
        chk("wrap_irq_early", 32'(act_irq), 32'd0);
        step(0, 12'hB83, 0, 0, '0);
        chk("wrap_hi_0", act_rd, 32'h0);
        chk("wrap_irq", 32'(act_irq), 32'(OF_EN));
        step(0, 12'h323, 0, 0, '0);
        chk("wrap_of", act_rd, OF_EN ? 32'h80000001 : 32'h1);

        // writes to read-only / unmapped are flagged and ignored
        step(1, 12'hC00, 32'h123, 0, '0);
        chk("wr_shadow_ill", 32'(act_ill), 32'd1);
        step(1, 12'h7FF, 32'h123, 0, '0);
        chk("wr_unmapped_ill", 32'(act_ill), 32'd1);
        chk("wr_unmapped_rd", act_rd, 32'd0);
        step(0, 12'hC00, 0, 0, '0);
        chk_model("ro_nochange");
        step(1, 12'hB80, 32'hFFFFFFFF, 0, '0);
        step(0, 12'hB80, 0, 0, '0);
        chk("mcycleh_trunc", act_rd, 32'h000000FF);

        // random traffic vs model
        for (int i = 0; i < 600; i++) begin
            logic [11:0] a = raddr[$urandom_range(raddr.size() - 1)];
            logic w = ($urandom_range(3) == 0);
            logic [31:0] d = $urandom;
            if (a == 12'h320) d = d & 32'h7A;
            if ((a & 12'hFE0) == 12'h320 && $urandom_range(1)) d = (d & 32'h80000000) | 32'($urandom_range(EW));
            step(w, a, d, 1'($urandom), EW'($urandom));
            chk_model($sformatf("rnd%0d_%03h", i, a));
        end

        // asynchronous reset mid-count
        step(0, 12'hB00, 0, 0, '0);
        @(posedge clock); #3;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_mcycle", rdata, 32'h0);
        chk("async_rst_irq", 32'(ovf_irq), 32'd0);
        addr = 12'h323; #1;
        chk("async_rst_evt", rdata, 32'h0);
        @(posedge clock); #1 reset_n = 1'b1;
        step(0, 12'hB00, 0, 0, '0);
        chk_model("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
